// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit: the FSM
//               state encoding, RV32I load/store funct3 codes and the
//               illegal-funct3 decode.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // RV32I funct3 encodings shared by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Loads accept b/h/w/bu/hu; stores accept only b/h/w.
  function automatic logic is_illegal_f3(input logic write, input logic [2:0] f3);
    logic illegal;
    if (write) begin
      illegal = f3[2] || (f3[1:0] == 2'b11);
    end else begin
      illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    end
    return illegal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane steering for the load/store unit.
//               Merges store data into an old word (sb/sh/sw) and extracts
//               and sign/zero-extends load data from a word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] new_data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane selection: bytes use both offset bits, halves only offset[1]
  assign sel_byte = word[{byte_off, 3'b000} +: 8];
  assign sel_half = word[{byte_off[1], 4'b0000} +: 16];

  // Store merge: replace only the addressed lane of the old word
  always_comb begin
    merged = word;
    case (funct3[1:0])
      2'b00:   merged[{byte_off, 3'b000} +: 8]        = new_data[7:0];
      2'b01:   merged[{byte_off[1], 4'b0000} +: 16]   = new_data[15:0];
      default: merged = new_data;
    endcase
  end

  // Load extract: pick the lane and extend according to funct3
  always_comb begin
    extracted = 32'h0;
    case (funct3)
      F3_B:    extracted = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    extracted = {{16{sel_half[15]}}, sel_half};
      F3_W:    extracted = word;
      F3_BU:   extracted = {24'h0, sel_byte};
      F3_HU:   extracted = {16'h0, sel_half};
      default: extracted = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage initiator for a word-wide data memory. Converts
//               lb/lh/lw/lbu/lhu/sb/sh/sw into word accesses, performing
//               sb/sh as read-modify-write, stalling the pipeline while busy
//               and flagging misaligned / illegal accesses.
// Config      : `define LSU_MISALIGN_CHECK_EN to enable alignment checking;
//               when undefined only illegal funct3 faults are reported.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int BIT_SIZE       = 8,
  parameter bit STALL_ON_FAULT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        access_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        fault_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_misaligned;
  logic        req_fault;
  logic [31:0] word_addr;
  logic [31:0] merged_word;
  logic [31:0] extracted_word;

  // Word address: the memory's word index sits in [BIT_SIZE+1:2]
  assign word_addr = {addr_q[31:BIT_SIZE+2], addr_q[BIT_SIZE+1:2], 2'b00};

  // Alignment decode of the incoming request
  always_comb begin
    req_misaligned = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      default: req_misaligned = 1'b0;
    endcase
`endif
  end

  assign req_fault = req_misaligned || is_illegal_f3(req_write, req_funct3);

  lsu_lane_align u_lane_align (
    .word      (rdata_q),
    .new_data  (wdata_q),
    .funct3    (funct3_q),
    .byte_off  (addr_q[1:0]),
    .merged    (merged_word),
    .extracted (extracted_word)
  );

  // State register; async reset drops mem_we immediately, aborting any RMW
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= 32'h0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      write_q  <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        write_q  <= req_write;
        fault_q  <= req_fault;
      end
      if (state_q == RD) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Next-state and memory/pipeline outputs
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    done         = 1'b0;
    load_data    = 32'h0;
    access_fault = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_fault) begin
            state_d = DONE;
          end else if (req_write && (req_funct3 == F3_W)) begin
            state_d = WR;  // full-word store needs no read
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        mem_addr = word_addr;
        state_d  = write_q ? WR : DONE;
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = merged_word;
        state_d   = DONE;
      end
      DONE: begin
        if (STALL_ON_FAULT && fault_q && req_valid) begin
          state_d = DONE;  // hold the fault until the pipeline withdraws
        end else begin
          done         = 1'b1;
          access_fault = fault_q;
          load_data    = (fault_q || write_q) ? 32'h0 : extracted_word;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = req_valid && !done;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: directed scenarios
//               followed by random loads/stores checked against a word-array
//               reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        access_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  int total;
  int passed;

  load_store_unit #(.BIT_SIZE(8), .STALL_ON_FAULT(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .done         (done),
    .load_data    (load_data),
    .access_fault (access_fault),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word memory: combinational read, whole-word write
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = idx[5:0];
    pl_data = data;
    ref_mem[idx] = data;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic ill;
    logic mis;
    if (wr) ill = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) mis = 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) mis = 1'b1;
`endif
    return ill || mis;
  endfunction

  function automatic int m_latency(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (m_fault(wr, f3, a)) return 1;
    if (!wr) return 2;
    if (f3 == 3'd2) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    w = ref_mem[(a / 4) % 64];
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] wd, input logic [31:0] old);
    logic [31:0] mask;
    int sh;
    if (f3 == 3'd0) begin
      mask = 32'hFF;   sh = 8 * (a % 4);
    end else if (f3 == 3'd1) begin
      mask = 32'hFFFF; sh = 16 * ((a / 2) % 2);
    end else begin
      return wd;
    end
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // One complete access; checks it against the model, returns observed data
  task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic drop, input string tag,
                        output logic [31:0] ld_out, output logic f_out);
    logic        efault;
    int          elat;
    logic [31:0] exp_word;
    int          lat;
    int          we_cnt;
    logic        stall_bad;
    logic        got_done;
    logic [31:0] we_addr;
    logic [31:0] we_data;
    int          idx;
    idx      = (a / 4) % 64;
    efault   = m_fault(wr, f3, a);
    elat     = m_latency(wr, f3, a);
    exp_word = m_store(f3, a, wd, ref_mem[idx]);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    lat = 0; we_cnt = 0; stall_bad = 1'b0; got_done = 1'b0;
    we_addr = 32'h0; we_data = 32'h0; ld_out = 32'hX; f_out = 1'bX;
    for (int c = 0; c < 8 && !got_done; c++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++; we_addr = mem_addr; we_data = mem_wdata;
      end
      if (done) begin
        got_done = 1'b1; ld_out = load_data; f_out = access_fault;
        if (stall) stall_bad = 1'b1;
      end else begin
        if (stall !== req_valid) stall_bad = 1'b1;
        @(posedge clk);
        lat++;
        if (drop && lat == 1) #1 req_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    check({tag, " done_seen"}, {31'h0, got_done}, 32'h1);
    check({tag, " latency"}, lat, elat);
    check({tag, " fault"}, {31'h0, f_out}, {31'h0, efault});
    check({tag, " stall"}, {31'h0, stall_bad}, 32'h0);
    check({tag, " we_count"}, we_cnt, (wr && !efault) ? 1 : 0);
    if (!wr || efault) check({tag, " load_data"}, ld_out, efault ? 32'h0 : m_load(f3, a));
    if (wr && !efault) begin
      ref_mem[idx] = exp_word;
      check({tag, " we_addr"}, we_addr, {24'h0, a[7:2], 2'b00});
      check({tag, " we_data"}, we_data, exp_word);
    end
    check({tag, " mem_word"}, mem[idx], ref_mem[idx]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ld;
    logic        f;
    total = 0; passed = 0;
    rst = 1'b1; pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;

    // Preload memory while held in reset
    for (int i = 0; i < 64; i++) poke(i, 32'h0);
    poke(1, 32'h0000_2222);
    poke(2, 32'h0000_7777);

    // Reset state
    @(negedge clk);
    check("rst done",      {31'h0, done},         32'h0);
    check("rst mem_we",    {31'h0, mem_we},       32'h0);
    check("rst fault",     {31'h0, access_fault}, 32'h0);
    check("rst load_data", load_data, 32'h0);
    check("rst mem_addr",  mem_addr,  32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst stall",     {31'h0, stall},        32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset during the WR cycle of sb @0x04 must not write
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h04; req_wdata = 32'h0000_00CD;
    @(posedge clk);  // -> RD
    @(posedge clk);  // -> WR
    @(negedge clk);
    check("rmw_rst we_before", {31'h0, mem_we}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rmw_rst we_after",  {31'h0, mem_we}, 32'h0);
    check("rmw_rst done",      {31'h0, done},   32'h0);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rmw_rst word1", mem[1], 32'h0000_2222);

    // Directed test plan
    run_op(1'b0, 3'd2, 32'h04, 32'h0, 1'b0, "lw_after_rst", ld, f);
    run_op(1'b0, 3'd0, 32'h04, 32'h0, 1'b0, "lb_04", ld, f);
    check("lb_04 value", ld, 32'h0000_0022);
    run_op(1'b0, 3'd1, 32'h08, 32'h0, 1'b0, "lh_08", ld, f);
    check("lh_08 value", ld, 32'h0000_7777);
    run_op(1'b1, 3'd0, 32'h05, 32'h0000_00AB, 1'b0, "sb_05", ld, f);
    check("sb_05 word1", mem[1], 32'h0000_AB22);
    run_op(1'b0, 3'd0, 32'h05, 32'h0, 1'b0, "lb_05", ld, f);
    check("lb_05 value", ld, 32'hFFFF_FFAB);
    run_op(1'b0, 3'd4, 32'h05, 32'h0, 1'b0, "lbu_05", ld, f);
    check("lbu_05 value", ld, 32'h0000_00AB);
    run_op(1'b1, 3'd1, 32'h0A, 32'h0000_BEEF, 1'b0, "sh_0A", ld, f);
    check("sh_0A word2", mem[2], 32'hBEEF_7777);
    run_op(1'b0, 3'd5, 32'h0A, 32'h0, 1'b0, "lhu_0A", ld, f);
    check("lhu_0A value", ld, 32'h0000_BEEF);
    run_op(1'b0, 3'd1, 32'h0A, 32'h0, 1'b0, "lh_0A", ld, f);
    check("lh_0A value", ld, 32'hFFFF_BEEF);
    run_op(1'b1, 3'd2, 32'h0C, 32'hDEAD_BEEF, 1'b0, "sw_0C", ld, f);
    run_op(1'b0, 3'd2, 32'h0C, 32'h0, 1'b0, "lw_0C", ld, f);
    check("lw_0C value", ld, 32'hDEAD_BEEF);
    run_op(1'b0, 3'd2, 32'h06, 32'h0, 1'b0, "lw_06", ld, f);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lw_06 fault", {31'h0, f}, 32'h1);
    check("lw_06 value", ld, 32'h0);
`else
    check("lw_06 fault", {31'h0, f}, 32'h0);
    check("lw_06 value", ld, 32'h0000_AB22);
`endif
    run_op(1'b0, 3'd3, 32'h00, 32'h0, 1'b0, "ld_f011", ld, f);
    check("ld_f011 fault", {31'h0, f}, 32'h1);
    run_op(1'b1, 3'd4, 32'h10, 32'h1234_5678, 1'b0, "st_f100", ld, f);
    check("st_f100 fault", {31'h0, f}, 32'h1);

    // Random traffic, sometimes withdrawing req_valid mid-access
    for (int n = 0; n < 80; n++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic        drop;
      wr   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      a    = 32'($urandom_range(0, 255));
      wd   = $urandom;
      drop = ($urandom_range(0, 3) == 0);
      run_op(wr, f3, a, wd, drop, $sformatf("rnd%0d", n), ld, f);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Pipeline-side initiator for the word-wide data memory: the MEM-stage block that turns lb/lh/lw/lbu/lhu/sb/sh/sw into word accesses.
- The memory reads combinationally and writes whole words only, so sb/sh run as read-modify-write through a small FSM.
- Stalls the pipeline while an access is in flight.
- Returns sign- or zero-extended load data and flags misaligned or illegal accesses.

Parameters:
- BIT_SIZE, 8, word-index width of the target memory; memory word index = addr[BIT_SIZE+1:2].
- STALL_ON_FAULT, 0, if 1 a faulting request holds done low until req_valid drops. If 0, a fault completes like a normal access.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline presents a memory instruction; held stable until done.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load or store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store source register.
- stall  out  1  combinational: req_valid && !done.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; valid while done=1, otherwise 0.
- access_fault  out  1  valid with done: misaligned or illegal funct3.
- mem_we  out  1  word write enable to memory.
- mem_addr  out  32  word-aligned byte address; bits[1:0]=0.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- States: IDLE, RD, WR, DONE. State register resets asynchronously to IDLE.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, done=0, load_data=0, access_fault=0. rdata_q and all request latches reset to 0.
- IDLE, req_valid=1: latch addr, funct3, wdata and write; decode.
  - Fault: go to DONE with the fault flag set; no memory access.
  - Load: go to RD.
  - sw: go to WR.
  - sb/sh: go to RD.
- RD: drive mem_addr = {addr[31:2],2'b00} and mem_we=0. Capture mem_rdata into rdata_q.
  - Load: go to DONE.
  - sb/sh: go to WR.
- WR: mem_we=1, mem_addr as in RD, then go to DONE.
  - sw: mem_wdata = wdata.
  - sb: rdata_q with byte lane addr[1:0] replaced by wdata[7:0].
  - sh: rdata_q with half lane addr[1] replaced by wdata[15:0].
- DONE: done=1. load_data is extracted from rdata_q:
  - lb/lh: byte/half at the lane, sign-extended.
  - lbu/lhu: zero-extended.
  - lw: whole word.
  - Go to IDLE; a new request can be accepted the following cycle.
- Latency from request to done: loads 2 cycles, sw 2, sb/sh 3, faults 1. This is independent of req_valid once accepted.
- Fault conditions:
  - Misaligned: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0.
  - Illegal: load funct3 ∈ {011,110,111}; store funct3[2]=1 or 011.
  - On a fault: access_fault=1 with done, load_data=0, mem_we never asserted.
- req_valid dropping mid-access does not abort; the access completes.
- rst mid-access, including WR: mem_we falls immediately (asynchronous) and the FSM returns to IDLE. A partial RMW never writes.
- mem_we is high for exactly one cycle per store and is never high outside WR.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: misalignment detection as above.
- Undefined: alignment is not checked.
  - Address low bits are ignored for lw/sw.
  - Half lane for lh/sh is taken from addr[1] only.
  - access_fault reports illegal funct3 only.

Decomposition:
- Package lsu_pkg:
  - state enum lsu_state_t {IDLE,RD,WR,DONE}.
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module lsu_lane_align: purely combinational.
  - Store merge: old word, new data, funct3, addr[1:0] → merged word.
  - Load extract/extend: word, funct3, addr[1:0] → load_data.

Test Plan:
- Memory word1=0x00002222, word2=0x00007777; lb @0x04 → done at +2 cycles, load_data=0x00000022; lh @0x08 → 0x00007777.
- sb wdata=0x000000AB @0x05 → RD then WR, mem_we one cycle, mem_wdata=0x0000AB22 at mem_addr 0x04; then lb @0x05 → 0xFFFFFFAB, lbu @0x05 → 0x000000AB.
- sh wdata=0x0000BEEF @0x0A → word2=0xBEEF7777; lhu @0x0A → 0x0000BEEF; lh → 0xFFFFBEEF.
- sw 0xDEADBEEF @0x0C → done at +2, no RD cycle; lw @0x0C → 0xDEADBEEF. Stall is high every cycle before done.
- lw @0x06 and load funct3=011 @0x00 → done at +1, access_fault=1, load_data=0, mem_we stays 0. With LSU_MISALIGN_CHECK_EN undefined, lw @0x06 returns word1 with no fault.
- sb @0x04, assert rst during the WR cycle → mem_we drops the same instant, state IDLE, word1 unchanged (0x00002222).
